mod_sort8: RTL and testbench

- Sequenced sorting engine for a buffer of 16-bit unsigned words.
- Accepts N words over a valid/ready input stream and sorts them in place with bubble sort.
- Exactly one shared mod_comp16 magnitude comparator performs the sort, one compare-and-swap per cycle.
- Emits the sorted words on a valid/ready output stream; sits between a producer and a consumer in the lab datapath.

---
 rtl/mod_sort_pkg.sv | 19 +
 rtl/mod_sort8_if.sv | 26 ++
 rtl/mod_comp16.sv | 17 +
 rtl/mod_sort_ctrl.sv | 113 +++++++++++
 rtl/mod_sort8.sv | 102 ++++++++++
 tb/tb_mod_sort8.sv | 239 +++++++++++++++++++++++
 6 files changed

// File: rtl/mod_sort_pkg.sv
// Shared constants and helpers for the mod_sort8 bubble-sort engine.
package mod_sort_pkg;

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_SORT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int W            = 16;
  localparam int SWAP_CNT_MAX = 255;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'(SWAP_CNT_MAX)) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/mod_sort8_if.sv
// Producer/consumer streams plus status of the mod_sort8 engine.
interface mod_sort8_if;
  import mod_sort_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         desc;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;
  logic [7:0]   swap_cnt;

  modport master (
    output in_valid, in_data, desc, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy, swap_cnt
  );

  modport slave (
    input  in_valid, in_data, desc, out_ready,
    output in_ready, out_valid, out_data, out_last, busy, swap_cnt
  );

endinterface

// File: rtl/mod_comp16.sv
// 16-bit magnitude comparator with cascade inputs for ties.
module mod_comp16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        gt_in,
  input  logic        eq_in,
  input  logic        lt_in,
  output logic        gt,
  output logic        eq,
  output logic        lt
);

  assign gt = (a > b) | ((a == b) & gt_in);
  assign eq = (a == b) & eq_in;
  assign lt = (a < b) | ((a == b) & lt_in);

endmodule

// File: rtl/mod_sort_ctrl.sv
// Sequencer for mod_sort8: load/sort/drain FSM with write, read, pair and pass counters.
module mod_sort_ctrl
  import mod_sort_pkg::*;
#(
  parameter  int N  = 8,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          out_ready,
  input  logic          swap,
  output logic          in_ready,
  output logic          out_valid,
  output logic          out_last,
  output logic          busy,
  output logic          wr_en,
  output logic          first_acc,
  output logic          sort_start,
  output logic          swap_en,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic [AW-1:0] wptr,
  output logic [AW-1:0] idx
);

  localparam logic [AW-1:0] ZERO      = {AW{1'b0}};
  localparam logic [AW-1:0] ONE       = AW'(1);
  localparam logic [AW-1:0] LAST      = AW'(N - 1);
  localparam logic [AW-1:0] LAST_PAIR = AW'(N - 2);

  logic [1:0]    state_r, state_s;
  logic [AW-1:0] wptr_r, rptr_r, rptr_s, idx_r, pass_r;
  logic          pass_swapped_r;
  logic          in_ready_r, out_valid_r, out_last_r, busy_r;
  logic          accept_s, hs_s, in_sort_s, last_pair_s, sort_done_s;

  // Next-state, handshake and datapath-enable decode.
  always_comb begin
    accept_s    = in_ready_r & in_valid;
    hs_s        = out_valid_r & out_ready;
    in_sort_s   = (state_r == ST_SORT);
    last_pair_s = (idx_r == LAST_PAIR);
    swap_en     = in_sort_s & swap;
    // A swap on the final pair still counts as a dirty pass; the pass cap overrides.
    sort_done_s = in_sort_s & last_pair_s &
                  (~(pass_swapped_r | swap_en) | (pass_r == LAST));
    state_s = state_r;
    case (state_r)
      ST_LOAD:  if (accept_s && (wptr_r == LAST)) state_s = ST_SORT;  else state_s = state_r;
      ST_SORT:  if (sort_done_s)                   state_s = ST_DRAIN; else state_s = state_r;
      ST_DRAIN: if (hs_s && (rptr_r == LAST))      state_s = ST_LOAD;  else state_s = state_r;
      default:  state_s = ST_LOAD;
    endcase
    if (hs_s) begin
      if (rptr_r == LAST) rptr_s = ZERO;
      else                rptr_s = rptr_r + ONE;
    end else begin
      rptr_s = rptr_r;
    end
    wr_en      = accept_s;
    first_acc  = accept_s & (wptr_r == ZERO);
    sort_start = accept_s & (wptr_r == LAST);
    rd_en      = sort_done_s | (hs_s & (rptr_r != LAST));
    rd_addr    = rptr_s;
  end

  // State, counters and registered stream/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= ST_LOAD;
      wptr_r         <= ZERO;
      rptr_r         <= ZERO;
      idx_r          <= ZERO;
      pass_r         <= ZERO;
      pass_swapped_r <= 1'b0;
      in_ready_r     <= 1'b1;
      out_valid_r    <= 1'b0;
      out_last_r     <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      state_r     <= state_s;
      rptr_r      <= rptr_s;
      in_ready_r  <= (state_s == ST_LOAD);
      busy_r      <= (state_s == ST_SORT);
      out_valid_r <= (state_s == ST_DRAIN);
      out_last_r  <= (state_s == ST_DRAIN) && (rptr_s == LAST);
      if (accept_s) begin
        wptr_r <= (wptr_r == LAST) ? ZERO : wptr_r + ONE;
      end
      if (in_sort_s && !last_pair_s) begin
        idx_r          <= idx_r + ONE;
        pass_swapped_r <= pass_swapped_r | swap_en;
      end else begin
        idx_r          <= ZERO;
        pass_swapped_r <= 1'b0;
      end
      if (in_sort_s && last_pair_s) begin
        pass_r <= pass_r + ONE;
      end else if (!in_sort_s) begin
        pass_r <= ZERO;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign busy      = busy_r;
  assign wptr      = wptr_r;
  assign idx       = idx_r;

endmodule

// File: rtl/mod_sort8.sv
// In-place bubble-sort engine: N-word buffer, one shared comparator, one compare-and-swap per cycle.
module mod_sort8
  import mod_sort_pkg::*;
#(
  parameter int N = 8
) (
  input logic       clk,
  input logic       rst,
  mod_sort8_if.slave bus
);

  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] ONE = AW'(1);

  logic [W-1:0]  mem_r [N];
  logic [W-1:0]  a_s, b_s, rd_val_s, out_data_r;
  logic [AW-1:0] idx_s, idx_p1_s, wptr_s, rd_addr_s;
  logic          gt_s, eq_s, lt_s, swap_s, swap_en_s;
  logic          wr_en_s, first_acc_s, sort_start_s, rd_en_s;
  logic          desc_q_r;
  logic [7:0]    swap_cnt_r;

  mod_sort_ctrl #(.N(N)) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (bus.in_valid),
    .out_ready  (bus.out_ready),
    .swap       (swap_s),
    .in_ready   (bus.in_ready),
    .out_valid  (bus.out_valid),
    .out_last   (bus.out_last),
    .busy       (bus.busy),
    .wr_en      (wr_en_s),
    .first_acc  (first_acc_s),
    .sort_start (sort_start_s),
    .swap_en    (swap_en_s),
    .rd_en      (rd_en_s),
    .rd_addr    (rd_addr_s),
    .wptr       (wptr_s),
    .idx        (idx_s)
  );

  assign idx_p1_s = idx_s + ONE;
  assign a_s      = mem_r[idx_s];
  assign b_s      = mem_r[idx_p1_s];

  mod_comp16 u_comp (
    .a     (a_s),
    .b     (b_s),
    .gt_in (1'b0),
    .eq_in (1'b1),
    .lt_in (1'b0),
    .gt    (gt_s),
    .eq    (eq_s),
    .lt    (lt_s)
  );

  // Swap decision and a read port that sees a swap landing on the same edge.
  always_comb begin
    if (desc_q_r) swap_s = lt_s & ~eq_s;
    else          swap_s = gt_s & ~eq_s;
    rd_val_s = mem_r[rd_addr_s];
    if (swap_en_s && (rd_addr_s == idx_s)) begin
      rd_val_s = b_s;
    end else if (swap_en_s && (rd_addr_s == idx_p1_s)) begin
      rd_val_s = a_s;
    end else begin
      rd_val_s = mem_r[rd_addr_s];
    end
  end

  // Word buffer: loads from the input stream, exchanges pairs while sorting.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wptr_s] <= bus.in_data;
    end else if (swap_en_s) begin
      mem_r[idx_s]    <= b_s;
      mem_r[idx_p1_s] <= a_s;
    end
  end

  // Batch order, swap statistics and the registered output word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      desc_q_r   <= 1'b0;
      swap_cnt_r <= 8'd0;
      out_data_r <= {W{1'b0}};
    end else begin
      if (first_acc_s) desc_q_r <= bus.desc;
      if (sort_start_s) begin
        swap_cnt_r <= 8'd0;
      end else if (swap_en_s) begin
        swap_cnt_r <= sat_inc8(swap_cnt_r);
      end
      if (rd_en_s) out_data_r <= rd_val_s;
    end
  end

  assign bus.out_data = out_data_r;
  assign bus.swap_cnt = swap_cnt_r;

endmodule

// File: tb/tb_mod_sort8.sv
// Scoreboard bench for mod_sort8: directed batches, backpressure, mid-sort reset, held in_valid.
module tb_mod_sort8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mod_sort8_if bus ();

  mod_sort8 #(.N(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial forever #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          sort_cyc = 0;
  int          acc_cnt = 0;
  int          bad_acc = 0;
  logic        bp_mode = 1'b0;
  logic [16:0] exp_q [$];
  logic [15:0] in_vec  [8];
  logic [15:0] out_vec [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic issue_batch(input logic d, input logic hold, input logic push);
    int n;
    logic lst;
    if (push) begin
      for (int i = 0; i < 8; i++) begin
        lst = (i == 7);
        exp_q.push_back({lst, out_vec[i]});
      end
    end
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = in_vec[i];
      bus.desc     = d;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 500) begin
        @(negedge clk);
        n++;
      end
      if (!bus.in_ready) begin
        n_cmp++;
        n_bad++;
        $display("FAIL load_timeout: in_ready stuck at 0 for word %0d", i);
      end
      @(posedge clk);
      #1;
    end
    if (hold) bus.in_data = 16'h0007;
    else      bus.in_valid = 1'b0;
  endtask

  task automatic finish_batch(input int swaps, input int cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d words still expected", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
    chk("swap_cnt", 32'(bus.swap_cnt), swaps);
    if (cyc >= 0) chk("sort_cycles", sort_cyc, cyc);
  endtask

  // Output consumer pacing: always ready, or 1,0,0 repeating under backpressure.
  initial begin
    int ph;
    ph = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        bus.out_ready = (ph == 0);
        ph = (ph == 2) ? 0 : ph + 1;
      end else begin
        bus.out_ready = 1'b1;
      end
    end
  end

  // Monitor: scoreboard pops, stall stability, SORT cycle and acceptance counting.
  initial begin
    logic        held_v;
    logic [15:0] held_data;
    logic        held_last;
    logic [16:0] e;
    held_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_v = 1'b0;
      end else begin
        if (bus.busy) sort_cyc++;
        if (bus.in_valid && bus.in_ready) begin
          acc_cnt++;
          if (bus.busy || bus.out_valid) bad_acc++;
        end
        if (held_v && bus.out_valid) begin
          chk("stall_data", 32'(bus.out_data), 32'(held_data));
          chk("stall_last", 32'(bus.out_last), 32'(held_last));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_out: got %0h with nothing expected", bus.out_data);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", 32'(bus.out_data), 32'(e[15:0]));
            chk("out_last", 32'(bus.out_last), 32'(e[16]));
          end
        end
        held_v    = bus.out_valid && !bus.out_ready;
        held_data = bus.out_data;
        held_last = bus.out_last;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int n;
    bus.in_valid = 1'b0;
    bus.in_data  = 16'h0000;
    bus.desc     = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_last",  32'(bus.out_last), 0);
    chk("rst_busy",      32'(bus.busy), 0);
    chk("rst_swap_cnt",  32'(bus.swap_cnt), 0);
    chk("rst_out_data",  32'(bus.out_data), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("in_ready_after_rst", 32'(bus.in_ready), 1);

    // Reverse input, ascending: 7 sorting passes + 1 clean pass.
    in_vec  = '{16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    out_vec = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    sort_cyc = 0;
    issue_batch(1'b0, 1'b0, 1'b1);
    finish_batch(28, 56);

    // Already sorted: a single clean pass.
    in_vec  = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    sort_cyc = 0;
    issue_batch(1'b0, 1'b0, 1'b1);
    finish_batch(0, 7);

    // Descending with duplicates; 10 strict inversions means equal 3s never swapped.
    in_vec  = '{16'd3, 16'hFFFF, 16'd0, 16'd3, 16'h8000, 16'd1, 16'd3, 16'd2};
    out_vec = '{16'hFFFF, 16'h8000, 16'd3, 16'd3, 16'd3, 16'd2, 16'd1, 16'd0};
    sort_cyc = 0;
    issue_batch(1'b1, 1'b0, 1'b1);
    finish_batch(10, -1);

    // Backpressure during drain.
    in_vec  = '{16'd10, 16'd30, 16'd20, 16'd40, 16'd0, 16'd70, 16'd60, 16'd50};
    out_vec = '{16'd0, 16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70};
    bp_mode = 1'b1;
    issue_batch(1'b0, 1'b0, 1'b1);
    finish_batch(8, -1);
    bp_mode = 1'b0;

    // Asynchronous reset 10 cycles into SORT: batch discarded, no output expected.
    in_vec  = '{16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    issue_batch(1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    chk("busy_before_rst", 32'(bus.busy), 1);
    rst = 1'b1;
    #1;
    chk("arst_busy",      32'(bus.busy), 0);
    chk("arst_swap_cnt",  32'(bus.swap_cnt), 0);
    chk("arst_out_valid", 32'(bus.out_valid), 0);
    chk("arst_out_last",  32'(bus.out_last), 0);
    chk("arst_out_data",  32'(bus.out_data), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("arst_in_ready", 32'(bus.in_ready), 1);
    in_vec  = '{16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0, 16'd7, 16'd6};
    out_vec = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7};
    issue_batch(1'b0, 1'b0, 1'b1);
    finish_batch(16, -1);

    // in_valid held high: batch A, then 8 words of 7 only after A's last word.
    in_vec  = '{16'd2, 16'd1, 16'd4, 16'd3, 16'd6, 16'd5, 16'd8, 16'd7};
    out_vec = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    base = acc_cnt;
    bad_acc = 0;
    sort_cyc = 0;
    issue_batch(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), 16'h0007});
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while ((acc_cnt - base) < 16 && n < 2000);
    #1;
    bus.in_valid = 1'b0;
    chk("held_accepts", acc_cnt - base, 16);
    finish_batch(0, 21);
    chk("accepts_outside_load", bad_acc, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
